// File: rtl/edge_event_capture.sv
// rtl/edge_event_capture.sv - multi-channel synchronised edge detector with sticky status, irq and saturating counters
module edge_event_capture #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             signal_in,
    input  logic [2*WIDTH-1:0]           mode,
    input  logic [WIDTH-1:0]             irq_en,
    input  logic [WIDTH-1:0]             status_clear,
    input  logic [WIDTH-1:0]             count_clear,
    output logic [WIDTH-1:0]             sync_level,
    output logic [WIDTH-1:0]             edge_pulse,
    output logic [WIDTH-1:0]             status,
    output logic [WIDTH*COUNT_WIDTH-1:0] count,
    output logic                         irq
);

    localparam logic [2:0] SETTLE_CYCLES = 3'(SYNC_STAGES + 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]       prev;
    logic [2:0]             settle_cnt;
    logic [COUNT_WIDTH-1:0] cnt [WIDTH];
    logic [WIDTH-1:0]       rise;
    logic [WIDTH-1:0]       fall;
    logic [WIDTH-1:0]       qual;
    logic                   settling;

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign settling   = (settle_cnt != SETTLE_CYCLES);
    assign rise       = sync_level & ~prev;
    assign fall       = ~sync_level & prev;

    // Edges are ignored until the chain has flushed the pre-reset state.
    always_comb begin
        qual = '0;
        for (int i = 0; i < WIDTH; i++) begin
            qual[i] = ((rise[i] & mode[2*i]) | (fall[i] & mode[2*i+1])) & ~settling;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev       <= '0;
            settle_cnt <= '0;
            edge_pulse <= '0;
            status     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_q[0] <= signal_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev <= sync_level;
            if (settling) begin
                settle_cnt <= settle_cnt + 3'd1;
            end
            edge_pulse <= qual;
            for (int i = 0; i < WIDTH; i++) begin
                if (qual[i]) begin
                    status[i] <= 1'b1;
                end else if (status_clear[i]) begin
                    status[i] <= 1'b0;
                end
                // A clear coinciding with an event leaves that event counted.
                if (count_clear[i]) begin
                    cnt[i] <= qual[i] ? COUNT_WIDTH'(1) : '0;
                end else if (qual[i] && cnt[i] != COUNT_MAX) begin
                    cnt[i] <= cnt[i] + COUNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt[i];
        end
    end

    assign irq = |(status & irq_en);

endmodule

// File: tb/tb_edge_event_capture.sv
// tb/tb_edge_event_capture.sv - directed self-checking bench for edge_event_capture
module tb_edge_event_capture;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a: WIDTH=1, SYNC_STAGES=2, COUNT_WIDTH=8
    logic       rst, sig, irq_en, sclr, cclr;
    logic [1:0] mode;
    logic       sync_a, pulse_a, status_a, irq_a;
    logic [7:0] count_a;

    // Instance b: WIDTH=4, SYNC_STAGES=3, COUNT_WIDTH=3
    logic        rst_b;
    logic [3:0]  sig_b, irq_en_b, sclr_b, cclr_b;
    logic [7:0]  mode_b;
    logic [3:0]  sync_b, pulse_b, status_b;
    logic [11:0] count_b;
    logic        irq_b;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt, first_idx, last_idx;
    logic       seen_a;
    logic [3:0] seen_b;

    edge_event_capture #(.WIDTH(1), .SYNC_STAGES(2), .COUNT_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .signal_in(sig), .mode(mode), .irq_en(irq_en),
        .status_clear(sclr), .count_clear(cclr), .sync_level(sync_a),
        .edge_pulse(pulse_a), .status(status_a), .count(count_a), .irq(irq_a)
    );

    edge_event_capture #(.WIDTH(4), .SYNC_STAGES(3), .COUNT_WIDTH(3)) dut_b (
        .clk(clk), .rst(rst_b), .signal_in(sig_b), .mode(mode_b), .irq_en(irq_en_b),
        .status_clear(sclr_b), .count_clear(cclr_b), .sync_level(sync_b),
        .edge_pulse(pulse_b), .status(status_b), .count(count_b), .irq(irq_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            seen_a = seen_a | pulse_a;
            seen_b = seen_b | pulse_b;
            if (pulse_a) pulse_cnt++;
        end
    endtask

    task automatic reset_a();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sig = 1'b0; mode = 2'b01; irq_en = 1'b0; sclr = 1'b0; cclr = 1'b0;
        rst_b = 1'b1; sig_b = '0; mode_b = '0; irq_en_b = '0; sclr_b = '0; cclr_b = '0;
        seen_a = 1'b0; seen_b = '0; pulse_cnt = 0;

        // Reset state
        tick(2);
        check("rst_sync", 32'(sync_a), 32'd0);
        check("rst_pulse", 32'(pulse_a), 32'd0);
        check("rst_status", 32'(status_a), 32'd0);
        check("rst_count", 32'(count_a), 32'd0);
        check("rst_irq", 32'(irq_a), 32'd0);

        // Test 1: rise in mode 01, pulse exactly at N+2
        rst = 1'b0;
        tick(5);
        sig = 1'b1;
        tick(1); check("t1_n0_pulse", 32'(pulse_a), 32'd0);
        tick(1); check("t1_n1_pulse", 32'(pulse_a), 32'd0);
        tick(1); check("t1_n2_pulse", 32'(pulse_a), 32'd1);
        check("t1_status", 32'(status_a), 32'd1);
        check("t1_count", 32'(count_a), 32'd1);
        tick(1); check("t1_n3_pulse", 32'(pulse_a), 32'd0);
        check("t1_sync", 32'(sync_a), 32'd1);

        // Test 2: input held high through reset, then fall in mode 10
        reset_a();
        seen_a = 1'b0;
        tick(6);
        check("t2_no_rise", 32'(seen_a), 32'd0);
        check("t2_status", 32'(status_a), 32'd0);
        check("t2_count", 32'(count_a), 32'd0);
        check("t2_sync", 32'(sync_a), 32'd1);
        mode = 2'b10;
        sig = 1'b0;
        tick(3);
        check("t2_fall_pulse", 32'(pulse_a), 32'd1);
        check("t2_fall_count", 32'(count_a), 32'd1);
        tick(1);
        check("t2_fall_width", 32'(pulse_a), 32'd0);

        // Test 3: toggle every cycle in mode 11, then mode 00
        reset_a();
        tick(5);
        mode = 2'b11;
        pulse_cnt = 0; first_idx = -1; last_idx = -1;
        for (int i = 0; i < 13; i++) begin
            if (i < 10) sig = ~sig;
            tick(1);
            if (pulse_a) begin
                if (first_idx < 0) first_idx = i;
                last_idx = i;
            end
        end
        check("t3_pulses", 32'(pulse_cnt), 32'd10);
        check("t3_first", 32'(first_idx), 32'd2);
        check("t3_last", 32'(last_idx), 32'd11);
        check("t3_count", 32'(count_a), 32'd10);
        mode = 2'b00;
        pulse_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            if (i < 10) sig = ~sig;
            tick(1);
        end
        check("t3_off_pulses", 32'(pulse_cnt), 32'd0);
        check("t3_off_count", 32'(count_a), 32'd10);

        // Mode changes on a steady input create no event
        seen_a = 1'b0;
        mode = 2'b11; tick(1);
        mode = 2'b01; tick(1);
        mode = 2'b10; tick(2);
        check("mode_chg_pulse", 32'(seen_a), 32'd0);
        check("mode_chg_count", 32'(count_a), 32'd10);

        // Test 4: status clear vs simultaneous event
        mode = 2'b01;
        irq_en = 1'b1;
        sclr = 1'b1; tick(1); sclr = 1'b0;
        check("t4_clr_status", 32'(status_a), 32'd0);
        check("t4_clr_irq", 32'(irq_a), 32'd0);
        sig = 1'b1;
        tick(2);
        sclr = 1'b1;
        tick(1);
        check("t4_set_pulse", 32'(pulse_a), 32'd1);
        check("t4_set_wins", 32'(status_a), 32'd1);
        check("t4_set_irq", 32'(irq_a), 32'd1);
        check("t4_set_count", 32'(count_a), 32'd11);
        tick(1);
        sclr = 1'b0;
        check("t4_clr2_status", 32'(status_a), 32'd0);
        check("t4_clr2_irq", 32'(irq_a), 32'd0);

        // Test 5: saturation at 7 on instance b, then clear with a rise
        rst_b = 1'b1; tick(1);
        check("t5_rst_count", 32'(count_b), 32'd0);
        rst_b = 1'b0;
        tick(5);
        mode_b = 8'b00_00_00_01;
        for (int i = 0; i < 9; i++) begin
            sig_b = 4'b0001; tick(1);
            sig_b = 4'b0000; tick(1);
        end
        tick(4);
        check("t5_saturate", 32'(count_b), 32'd7);
        check("t5_status", 32'(status_b), 32'd1);
        sig_b = 4'b0001;
        tick(3);
        cclr_b = 4'b0001;
        tick(1);
        check("t5_clr_with_rise", 32'(count_b), 32'd1);
        tick(1);
        cclr_b = 4'b0000;
        check("t5_clr_alone", 32'(count_b), 32'd0);
        sig_b = 4'b0000;
        tick(4);

        // Test 6: channel independence and reset mid-pipeline
        rst_b = 1'b1; tick(1); rst_b = 1'b0;
        tick(5);
        mode_b = 8'b01_01_01_01;
        irq_en_b = 4'b0100;
        seen_b = '0;
        sig_b = 4'b0100;
        tick(4);
        check("t6_status", 32'(status_b), 32'h4);
        check("t6_irq", 32'(irq_b), 32'd1);
        check("t6_count", 32'(count_b), 32'h040);
        check("t6_pulses", 32'(seen_b), 32'h4);
        sig_b = 4'b0111;
        tick(1);
        rst_b = 1'b1; tick(1); rst_b = 1'b0;
        seen_b = '0;
        tick(8);
        check("t6_midrst_pulse", 32'(seen_b), 32'd0);
        check("t6_midrst_status", 32'(status_b), 32'd0);
        check("t6_midrst_count", 32'(count_b), 32'd0);
        check("t6_midrst_irq", 32'(irq_b), 32'd0);
        check("t6_midrst_sync", 32'(sync_b), 32'h7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
